// File: rtl/ccff_bitstream_loader.sv
// Serialises a word-wide bitstream into a configuration flip-flop chain and
// optionally re-circulates the chain once to compare load and readback parity.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 10,
    parameter int WORD_W    = 4,
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, SETUP, PULSE, VSETUP, VPULSE, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     bitsLeft_q, bitsLeft_d;
    logic [WW-1:0]     wordLeft_q, wordLeft_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              parIn_q, parIn_d;
    logic              parOut_q, parOut_d;
    logic              bsReady_q, bsReady_d;
    logic              head_q, head_d;
    logic              clkEn_q, clkEn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q    <= IDLE;
            bitsLeft_q <= '0;
            wordLeft_q <= '0;
            shift_q    <= '0;
            parIn_q    <= 1'b0;
            parOut_q   <= 1'b0;
            bsReady_q  <= 1'b0;
            head_q     <= 1'b0;
            clkEn_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitsLeft_q <= bitsLeft_d;
            wordLeft_q <= wordLeft_d;
            shift_q    <= shift_d;
            parIn_q    <= parIn_d;
            parOut_q   <= parOut_d;
            bsReady_q  <= bsReady_d;
            head_q     <= head_d;
            clkEn_q    <= clkEn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // The last pulse of a pass is recognised by the counter reaching one, so it never wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = FETCH;
            FETCH:  if (bs_valid && bsReady_q) state_d = SETUP;
            SETUP:  state_d = PULSE;
            PULSE: begin
                if (bitsLeft_q == BW'(1))
                    state_d = VERIFY_EN ? VSETUP : DONE;
                else if (wordLeft_q == WW'(1))
                    state_d = FETCH;
                else
                    state_d = SETUP;
            end
            VSETUP: state_d = VPULSE;
            VPULSE: state_d = (bitsLeft_q == BW'(1)) ? DONE : VSETUP;
            DONE:   if (start) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bitsLeft_d = bitsLeft_q;
        wordLeft_d = wordLeft_q;
        shift_d    = shift_q;
        parIn_d    = parIn_q;
        parOut_d   = parOut_q;
        head_d     = head_q;
        error_d    = error_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    bitsLeft_d = BW'(CHAIN_LEN);
                    parIn_d    = 1'b0;
                    parOut_d   = 1'b0;
                    error_d    = 1'b0;
                end
            end
            FETCH: begin
                if (bs_valid && bsReady_q) begin
                    shift_d    = bs_data;
                    wordLeft_d = WW'(WORD_W);
                end
            end
            SETUP: begin
                head_d  = shift_q[WORD_W-1];
                shift_d = shift_q << 1;
                parIn_d = parIn_q ^ shift_q[WORD_W-1];
            end
            PULSE: begin
                wordLeft_d = wordLeft_q - WW'(1);
                bitsLeft_d = (bitsLeft_q == BW'(1)) ? BW'(CHAIN_LEN) : bitsLeft_q - BW'(1);
            end
            VSETUP: begin
                head_d   = ccff_tail;
                parOut_d = parOut_q ^ ccff_tail;
            end
            VPULSE: begin
                bitsLeft_d = bitsLeft_q - BW'(1);
                if (bitsLeft_q == BW'(1)) error_d = (parIn_q != parOut_q);
            end
            default: ;
        endcase
        bsReady_d = (state_d == FETCH);
        clkEn_d   = (state_d == PULSE) || (state_d == VPULSE);
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = (state_d == DONE);
    end

    assign bs_ready    = bsReady_q;
    assign ccff_head   = head_q;
    assign ccff_clk_en = clkEn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
